// File: rtl/uart_tx_if.sv
// TX handshake between uart_ctrl (master) and the UART transmitter (slave).
interface uart_tx_if;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       err_clr;
   logic       tx;
   logic       tx_empty;
   logic       tx_busy;
   logic       tx_error;

   modport master (
      output tx_req, tx_data, err_clr,
      input  tx, tx_empty, tx_busy, tx_error
   );

   modport slave (
      input  tx_req, tx_data, err_clr,
      output tx, tx_empty, tx_busy, tx_error
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2
// stop bits. A one-byte holding register lets frames run back to back.
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
   parameter int STOP_BITS    = 1
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   generate
      if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
         $error("uart_tx: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t        state, state_d;
   logic [CW-1:0] baud_cnt, baud_d;
   logic [2:0]    bit_cnt, bit_d;
   logic          stop_cnt, stop_d;
   logic [7:0]    shift, shift_d;
   logic [7:0]    hold_data, hold_data_d;
   logic          hold_valid, hold_valid_d;
   logic          tx_q, tx_d;
   logic          err_q, err_d;
   logic          empty_q, busy_q;
   logic          load, overrun, baud_last, par_bit;

   assign baud_last = (baud_cnt == BAUD_LAST);
   // Parity comes from the latched shifter byte, never the live input.
   assign par_bit   = (PARITY == 2) ? ~(^shift) : ^shift;

   // Next-state, line level and holding-register update.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d      = state;
      baud_d       = baud_cnt + CW'(1);
      bit_d        = bit_cnt;
      stop_d       = stop_cnt;
      shift_d      = shift;
      tx_d         = tx_q;
      load         = 1'b0;
      overrun      = 1'b0;
      hold_valid_d = hold_valid;
      hold_data_d  = hold_data;

      case (state)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (hold_valid) begin
               load    = 1'b1;
               shift_d = hold_data;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
               tx_d    = shift[0];
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_cnt == 3'd7) begin
                  stop_d = 1'b0;
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_cnt + 3'd1;
                  tx_d  = shift[bit_cnt + 3'd1];
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               baud_d  = '0;
               stop_d  = 1'b0;
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (stop_cnt == STOP_LAST) begin
                  if (hold_valid) begin
                     // Chain straight into the next start bit: no idle gap.
                     load    = 1'b1;
                     shift_d = hold_data;
                     state_d = S_START;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A request is accepted if hold is empty or is being emptied this edge.
      if (load) hold_valid_d = 1'b0;
      if (bus.tx_req) begin
         if (!hold_valid || load) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.tx_data;
         end else begin
            overrun = 1'b1;
         end
      end

      // Sticky error: a new overrun beats a simultaneous clear.
      err_d = overrun ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift      <= '0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         tx_q       <= 1'b1;
         err_q      <= 1'b0;
         empty_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state      <= state_d;
         baud_cnt   <= baud_d;
         bit_cnt    <= bit_d;
         stop_cnt   <= stop_d;
         shift      <= shift_d;
         hold_data  <= hold_data_d;
         hold_valid <= hold_valid_d;
         tx_q       <= tx_d;
         err_q      <= err_d;
         empty_q    <= !hold_valid_d;
         busy_q     <= hold_valid_d || (state_d != S_IDLE);
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tx_empty = empty_q;
   assign bus.tx_busy  = busy_q;
   assign bus.tx_error = err_q;

endmodule
